// File: rtl/sort_checker_pkg.sv
// Shared types and default sizes for the sorter result checker.
package sort_pkg;

  localparam int DEF_DWIDTH      = 64;
  localparam int DEF_MAX_PKT_LEN = 256;
  localparam int DEF_CNT_WIDTH   = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_DWIDTH-1:0] data;
    logic                  sop;
    logic                  eop;
  } avst_beat_t;

  typedef struct packed {
    logic order;
    logic frame;
    logic len;
  } err_t;

endpackage

// File: rtl/sort_checker_if.sv
// Avalon-ST beat bundle; master drives the beat, slave drives ready.
interface sort_checker_if #(
  parameter int DWIDTH = sort_pkg::DEF_DWIDTH
);
  logic [DWIDTH-1:0] data;
  logic              startofpacket;
  logic              endofpacket;
  logic              valid;
  logic              ready;

  modport master (output data, startofpacket, endofpacket, valid, input ready);
  modport slave  (input data, startofpacket, endofpacket, valid, output ready);
endinterface

// File: rtl/sort_checker_skid_buf.sv
// Two-entry skid buffer with registered ready; head entry drives the output.
module avst_skid_buf
  import sort_pkg::*;
#(
  parameter type beat_t = avst_beat_t
) (
  input  logic  clk_i,
  input  logic  arst_n_i,
  input  beat_t in_beat,
  input  logic  in_valid,
  output logic  in_ready,
  output beat_t out_beat,
  output logic  out_valid,
  input  logic  out_ready
);

  beat_t      mem_q [2];
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       ready_q;
  logic       push;
  logic       pop;
  logic       wr_slot;

  assign push      = in_valid && ready_q;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = ready_q;
  assign out_beat  = mem_q[0];

  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    // slot 1 only when one entry remains after this cycle's pop
    wr_slot = pop ? (count_q == 2'd2) : (count_q == 2'd1);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      if (pop) mem_q[0] <= mem_q[1];
      if (push) mem_q[wr_slot] <= in_beat;
      count_q <= count_d;
      ready_q <= (count_d < 2'd2);
    end
  end

endmodule

// File: rtl/sort_checker.sv
// Forwards Avalon-ST beats through a skid buffer while checking packet order,
// framing and length; reports per-packet verdicts and saturating statistics.
//   state  | meaning
//   IDLE   | between packets, next accepted beat starts a packet
//   IN_PKT | inside a packet, comparing against the previous word
module sort_checker
  import sort_pkg::*;
#(
  parameter int DWIDTH      = DEF_DWIDTH,
  parameter int MAX_PKT_LEN = DEF_MAX_PKT_LEN,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 clr_i,
  sort_checker_if.slave        snk,
  sort_checker_if.master       src,
  output logic                 pkt_done_o,
  output logic                 pkt_ok_o,
  output logic [CNT_WIDTH-1:0] pkt_cnt_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic                 err_order_o,
  output logic                 err_frame_o,
  output logic                 err_len_o
);

  localparam int LW = $clog2(MAX_PKT_LEN + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_PKT_LEN);
  localparam logic [LW-1:0] LEN_OVF = LW'(MAX_PKT_LEN + 1);

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic              sop;
    logic              eop;
  } beat_t;

  beat_t in_beat;
  beat_t out_beat;
  logic  accept;

  assign in_beat = '{data: snk.data, sop: snk.startofpacket, eop: snk.endofpacket};

  avst_skid_buf #(.beat_t(beat_t)) u_skid (
    .clk_i     (clk_i),
    .arst_n_i  (arst_n_i),
    .in_beat   (in_beat),
    .in_valid  (snk.valid),
    .in_ready  (snk.ready),
    .out_beat  (out_beat),
    .out_valid (src.valid),
    .out_ready (src.ready)
  );

  assign src.data          = out_beat.data;
  assign src.startofpacket = out_beat.sop;
  assign src.endofpacket   = out_beat.eop;
  assign accept            = snk.valid && snk.ready;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] prev_q;
  logic [LW-1:0]     len_q, len_d;
  err_t              cur_q, cur_d;
  err_t              seen;
  err_t              done_err;
  logic              done;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cur_d    = cur_q;
    seen     = '0;
    done_err = '0;
    done     = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          seen.frame = !snk.startofpacket;
          len_d      = LW'(1);
          if (snk.endofpacket) begin
            done     = 1'b1;
            done_err = seen;
            cur_d    = '0;
          end else begin
            state_d = IN_PKT;
            cur_d   = seen;
          end
        end
        IN_PKT: begin
          if (snk.startofpacket) begin
            // Interrupting sop fails the open packet; a sop+eop here is
            // absorbed into that single failed verdict.
            seen.frame = 1'b1;
            done       = 1'b1;
            done_err   = cur_q | seen;
            cur_d      = '0;
            len_d      = LW'(1);
            state_d    = snk.endofpacket ? IDLE : IN_PKT;
          end else begin
            seen.order = (snk.data < prev_q);
            seen.len   = (len_q == LEN_MAX);
            if (len_q != LEN_OVF) len_d = len_q + 1'b1;
            if (snk.endofpacket) begin
              done     = 1'b1;
              done_err = cur_q | seen;
              cur_d    = '0;
              state_d  = IDLE;
            end else begin
              cur_d = cur_q | seen;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      prev_q      <= '0;
      len_q       <= '0;
      cur_q       <= '0;
      pkt_done_o  <= 1'b0;
      pkt_ok_o    <= 1'b0;
      pkt_cnt_o   <= '0;
      err_cnt_o   <= '0;
      err_order_o <= 1'b0;
      err_frame_o <= 1'b0;
      err_len_o   <= 1'b0;
    end else begin
      len_q      <= len_d;
      cur_q      <= cur_d;
      pkt_done_o <= done;
      if (accept) prev_q <= snk.data;
      if (done) pkt_ok_o <= ~|done_err;
      if (clr_i) begin
        pkt_cnt_o   <= '0;
        err_cnt_o   <= '0;
        err_order_o <= 1'b0;
        err_frame_o <= 1'b0;
        err_len_o   <= 1'b0;
      end else begin
        if (done && pkt_cnt_o != '1) pkt_cnt_o <= pkt_cnt_o + 1'b1;
        if (done && |done_err && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
        err_order_o <= err_order_o | seen.order;
        err_frame_o <= err_frame_o | seen.frame;
        err_len_o   <= err_len_o | seen.len;
      end
    end
  end

endmodule
